// File: rtl/maf_ctrl_pkg.sv
// Shared constants and types for the moving-average filter stream controller.
package maf_ctrl_pkg;
  localparam int N_BITS    = 32;
  localparam int WARMUP    = 7;
  localparam int FLUSH_LEN = 7;
  localparam int DECIM_W   = 8;
  localparam int CNT_MAX   = (WARMUP > FLUSH_LEN) ? WARMUP : FLUSH_LEN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WARMUP_C    = CNT_W'(WARMUP);
  localparam logic [CNT_W-1:0] FLUSH_LEN_C = CNT_W'(FLUSH_LEN);

  typedef enum logic [1:0] { CLEAR, RUN, FLUSH } state_e;
endpackage

// File: rtl/maf_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
module maf_out_slot
  import maf_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N_BITS-1:0] load_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [N_BITS-1:0] m_data,
  output logic              free
);
  logic              m_valid_q, m_valid_d;
  logic [N_BITS-1:0] m_data_q, m_data_d;

  always_comb begin
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign free    = !m_valid_q || m_ready;
endmodule

// File: rtl/maf_stream_ctrl.sv
// Sequencing controller for the 4-tap moving-average filter: strobes samples in,
// tracks warm-up, decimates results and handles clear / end-of-block flush.
module maf_stream_ctrl
  import maf_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N_BITS-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N_BITS-1:0]  m_data,
  input  logic [DECIM_W-1:0] decim,
  input  logic               flush_req,
  input  logic               clear_req,
  output logic               busy,
  output logic               filt_we,
  output logic               filt_rst,
  output logic [N_BITS-1:0]  filt_din,
  input  logic [N_BITS-1:0]  filt_dout
);
  state_e              state_q, state_d;
  logic                filt_we_q, filt_we_d;
  logic                cap_q, cap_d;
  logic [N_BITS-1:0]   filt_din_q, filt_din_d;
  logic [CNT_W-1:0]    warm_cnt_q, warm_cnt_d, flush_cnt_q, flush_cnt_d, warm_inc;
  logic [DECIM_W-1:0]  dec_cnt_q, dec_cnt_d, decim_q, decim_d, dec_nxt, dec_inc;
  logic                pend, out_free, slot_free, cap_active, eligible, load;
  logic                accept, flush_strobe;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == WARMUP_C) ? v : v + CNT_W'(1);
  endfunction

  // A result is captured the cycle after its strobe; a capture landing in CLEAR is stale.
  assign pend       = filt_we_q;
  assign cap_active = cap_q && (state_q != CLEAR);
  assign warm_inc   = sat_inc(warm_cnt_q);
  assign eligible   = (warm_inc == WARMUP_C);
  assign dec_nxt    = dec_cnt_q + DECIM_W'(1);
  assign dec_inc    = (dec_nxt == decim_q) ? '0 : dec_nxt;
  assign load       = cap_active && eligible && (dec_inc == '0);

  // A slot being filled this cycle is not free for the next strobe's result.
  assign slot_free    = out_free && !load;
  assign s_ready      = (state_q == RUN) && !pend && slot_free && !flush_req && !clear_req;
  assign accept       = s_valid && s_ready;
  assign flush_strobe = (state_q == FLUSH) && !pend && slot_free && !clear_req &&
                        (flush_cnt_q != FLUSH_LEN_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   state_d = RUN;
      RUN: begin
        if (clear_req)      state_d = CLEAR;
        else if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (clear_req)                                 state_d = CLEAR;
        else if (cap_q && flush_cnt_q == FLUSH_LEN_C) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state_q != RUN);
    filt_rst = (state_q == CLEAR);
  end

  always_comb begin
    warm_cnt_d  = warm_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    flush_cnt_d = flush_cnt_q;
    decim_d     = decim_q;
    filt_din_d  = filt_din_q;
    filt_we_d   = accept || flush_strobe;
    cap_d       = filt_we_q;
    if (state_q == CLEAR) begin
      warm_cnt_d  = '0;
      dec_cnt_d   = '0;
      flush_cnt_d = '0;
      decim_d     = (decim == '0) ? DECIM_W'(1) : decim;
    end else begin
      if (cap_active) begin
        warm_cnt_d = warm_inc;
        if (eligible) dec_cnt_d = dec_inc;
      end
      if (flush_strobe) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (accept)            filt_din_d = s_data;
    else if (flush_strobe) filt_din_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_we_q   <= 1'b0;
      cap_q       <= 1'b0;
      warm_cnt_q  <= '0;
      dec_cnt_q   <= '0;
      flush_cnt_q <= '0;
      decim_q     <= DECIM_W'(1);
    end else begin
      filt_we_q   <= filt_we_d;
      cap_q       <= cap_d;
      warm_cnt_q  <= warm_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      decim_q     <= decim_d;
    end
  end

  // Sample register only matters while filt_we is high.
  always_ff @(posedge clk) begin
    filt_din_q <= filt_din_d;
  end

  assign filt_we  = filt_we_q;
  assign filt_din = filt_din_q;

  maf_out_slot u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (filt_dout),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .free      (out_free)
  );
endmodule

// File: tb/tb_maf_stream_ctrl.sv
// Directed bench for maf_stream_ctrl with a behavioural 7-stage moving-average filter.
module tb_maf_stream_ctrl;
  import maf_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid, s_ready, m_valid, m_ready;
  logic [N_BITS-1:0]  s_data, m_data, filt_din, filt_dout;
  logic [DECIM_W-1:0] decim;
  logic               flush_req, clear_req, busy, filt_we, filt_rst;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt = 0, we_cnt = 0, zero_we_cnt = 0, frst_cnt = 0;
  logic [N_BITS-1:0] out_q[$];
  int                out_we[$];
  int b_acc, b_we, b_out, b_zero, b_frst, rem;
  logic found, done;
  logic [N_BITS-1:0] exp_fl [11] = '{80, 80, 80, 80, 80, 80, 80, 60, 40, 20, 0};

  always #5 clk = ~clk;

  maf_stream_ctrl dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .decim(decim),
    .flush_req(flush_req), .clear_req(clear_req), .busy(busy), .filt_we(filt_we),
    .filt_rst(filt_rst), .filt_din(filt_din), .filt_dout(filt_dout)
  );

  // Filter: 4 delay regs, 2 adder stages, 1 shift stage, all gated by filt_we.
  logic [N_BITS-1:0] r0, r1, r2, r3, s1, s2, sum, fo;
  always @(posedge clk) begin
    if (filt_rst) begin
      r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0; s1 <= '0; s2 <= '0; sum <= '0; fo <= '0;
    end else if (filt_we) begin
      r0 <= filt_din; r1 <= r0; r2 <= r1; r3 <= r2;
      s1 <= r0 + r1; s2 <= r2 + r3;
      sum <= s1 + s2;
      fo <= sum >> 2;
    end
  end
  assign filt_dout = fo;

  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
      if (filt_we) begin
        we_cnt <= we_cnt + 1;
        if (filt_din == '0) zero_we_cnt <= zero_we_cnt + 1;
      end
      if (filt_rst) frst_cnt <= frst_cnt + 1;
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        out_we.push_back(we_cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_BITS-1:0] v, input int n);
    int   got = 0;
    int   cyc = 0;
    logic acc;
    s_data = v; s_valid = 1'b1;
    while (got < n && cyc < 500) begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      if (acc) got++;
      cyc++;
    end
    s_valid = 1'b0;
    if (got != n) check("send_timeout", got, n);
  endtask

  task automatic do_clear(input logic [DECIM_W-1:0] d);
    int b;
    b = frst_cnt;
    decim = d; clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    check("clr_busy", 32'(busy), 1);
    tick(1);
    check("clr_pulse", frst_cnt - b, 1);
    check("clr_run", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; decim = 1;
    flush_req = 1'b0; clear_req = 1'b0;
    tick(3);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_filt_we", 32'(filt_we), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_filt_rst", 32'(filt_rst), 1);
    check("rst_m_data", m_data, 0);
    b_frst = frst_cnt;
    rst = 1'b0;
    tick(1);
    check("rel_filt_rst", 32'(filt_rst), 0);
    check("rel_busy", 32'(busy), 0);
    check("rel_pulse", frst_cnt - b_frst, 1);

    // constant 100, decim 1
    b_acc = acc_cnt; b_we = we_cnt; b_out = out_q.size();
    send(100, 12);
    tick(6);
    check("s1_accepted", acc_cnt - b_acc, 12);
    check("s1_count", out_q.size() - b_out, 6);
    if (out_q.size() > b_out) check("s1_first_at", out_we[b_out] - b_we, 7);
    for (int i = b_out; i < out_q.size(); i++) check("s1_data", out_q[i], 100);

    // constant 400, decim 3
    do_clear(3);
    b_we = we_cnt; b_out = out_q.size();
    send(400, 15);
    tick(6);
    check("s2_count", out_q.size() - b_out, 3);
    for (int i = 0; i < 3 && b_out + i < out_q.size(); i++) begin
      check("s2_data", out_q[b_out + i], 400);
      check("s2_at", out_we[b_out + i] - b_we, 9 + 3 * i);
    end

    // downstream stall after first result
    do_clear(1);
    m_ready = 1'b0;
    b_acc = acc_cnt; b_out = out_q.size();
    s_data = 100; s_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1'b1;
    end
    check("s3_seen", 32'(found), 1);
    for (int i = 0; i < 20; i++) begin
      check("s3_s_ready", 32'(s_ready), 0);
      check("s3_filt_we", 32'(filt_we), 0);
      check("s3_m_valid", 32'(m_valid), 1);
      check("s3_m_data", m_data, 100);
      @(negedge clk);
    end
    @(posedge clk); #1;
    check("s3_acc_at_stall", acc_cnt - b_acc, 7);
    m_ready = 1'b1;
    rem = 12 - (acc_cnt - b_acc);
    send(100, rem);
    tick(6);
    check("s3_count", out_q.size() - b_out, 6);
    for (int i = b_out; i < out_q.size(); i++) check("s3_data", out_q[i], 100);

    // flush after 10 x 80
    do_clear(1);
    b_we = we_cnt; b_zero = zero_we_cnt; b_out = out_q.size(); b_frst = frst_cnt;
    send(80, 10);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    check("s4_busy", 32'(busy), 1);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    @(posedge clk); #1;
    check("s4_back_run", 32'(done), 1);
    check("s4_zero_strobes", zero_we_cnt - b_zero, 7);
    check("s4_all_strobes", we_cnt - b_we, 17);
    check("s4_clear_pulse", frst_cnt - b_frst, 1);
    check("s4_count", out_q.size() - b_out, 11);
    for (int i = 0; i < 11 && b_out + i < out_q.size(); i++) check("s4_data", out_q[b_out + i], exp_fl[i]);
    b_out = out_q.size();
    send(40, 6);
    tick(6);
    check("s4_rewarm_none", out_q.size() - b_out, 0);
    send(40, 1);
    tick(6);
    check("s4_rewarm_one", out_q.size() - b_out, 1);
    if (out_q.size() > b_out) check("s4_rewarm_data", out_q[b_out], 40);

    // clear and flush together
    do_clear(1);
    send(200, 9);
    tick(4);
    b_zero = zero_we_cnt; b_we = we_cnt; b_frst = frst_cnt; b_out = out_q.size();
    clear_req = 1'b1; flush_req = 1'b1;
    tick(1);
    clear_req = 1'b0; flush_req = 1'b0;
    check("s5_filt_rst", 32'(filt_rst), 1);
    tick(3);
    check("s5_run", 32'(busy), 0);
    check("s5_pulse", frst_cnt - b_frst, 1);
    check("s5_no_strobes", we_cnt - b_we, 0);
    check("s5_no_zero", zero_we_cnt - b_zero, 0);
    send(200, 6);
    tick(6);
    check("s5_none", out_q.size() - b_out, 0);
    send(200, 1);
    tick(6);
    check("s5_one", out_q.size() - b_out, 1);
    if (out_q.size() > b_out) check("s5_data", out_q[b_out], 200);

    // async reset in the middle of a flush
    do_clear(1);
    send(80, 10);
    flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0;
    tick(3);
    check("s6_in_flush", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("s6_s_ready", 32'(s_ready), 0);
    check("s6_m_valid", 32'(m_valid), 0);
    check("s6_filt_we", 32'(filt_we), 0);
    check("s6_busy", 32'(busy), 1);
    check("s6_filt_rst", 32'(filt_rst), 1);
    check("s6_m_data", m_data, 0);
    tick(2);
    b_frst = frst_cnt; b_zero = zero_we_cnt; b_out = out_q.size();
    rst = 1'b0;
    tick(1);
    check("s6_rel_run", 32'(busy), 0);
    check("s6_rel_pulse", frst_cnt - b_frst, 1);
    send(40, 7);
    tick(6);
    check("s6_no_zero", zero_we_cnt - b_zero, 0);
    check("s6_one", out_q.size() - b_out, 1);
    if (out_q.size() > b_out) check("s6_data", out_q[b_out], 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
